// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline definitions: hazard-controller state encoding, drain depth
// and the halt opcode.
package pipe_hazard_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_HALTED = 2'd2
   } state_e;

   localparam logic [1:0]  DRAIN_DEPTH = 2'd3;
   localparam logic [31:0] HALT_OPCODE = 32'hFFFF_FFFF;

   function automatic logic is_halt(input logic [31:0] instr);
      return instr == HALT_OPCODE;
   endfunction

   // Register 0 is hardwired to zero, so a load targeting it never creates a hazard.
   function automatic logic load_use(input logic       memread,
                                     input logic [4:0] rt_ex,
                                     input logic [4:0] rs_id,
                                     input logic [4:0] rt_id);
      return memread && (rt_ex != 5'd0) && ((rt_ex == rs_id) || (rt_ex == rt_id));
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
module sat_counter16 (
   input  logic        clk,
   input  logic        rst,
   input  logic        inc_i,
   output logic [15:0] cnt_o
);

   logic [15:0] cnt_q;
   logic [15:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc_i && (cnt_q != 16'hFFFF)) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= 16'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch redirect flush and
// halt drain, with saturating stall/flush counters.
//
//   state     | meaning
//   ----------+-----------------------------------------------------
//   ST_RUN    | normal issue; load-use stalls and redirects handled
//   ST_DRAIN  | halt seen; fetch frozen while older instructions retire
//   ST_HALTED | pipeline empty, frozen until reset
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic        ex_memread,
   input  logic [4:0]  ex_rt,
   input  logic        mem_redirect,
   input  logic        id_halt,
   output logic        pc_write,
   output logic        if_id_write,
   output logic        if_id_flush,
   output logic        id_ex_flush,
   output logic        ex_mem_flush,
   output logic        halted,
   output logic [15:0] stall_cnt,
   output logic [15:0] flush_cnt
);

   state_e     state_q, state_d;
   logic [1:0] drain_q, drain_d;
   logic       lu_hit;
   logic       redir;
   logic       stall_inc;
   logic       flush_inc;

   assign lu_hit = (state_q == ST_RUN) && load_use(ex_memread, ex_rt, id_rs, id_rt);
   assign redir  = mem_redirect && ((state_q == ST_RUN) || (state_q == ST_DRAIN));

   always_comb begin
      state_d      = state_q;
      drain_d      = drain_q;
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_flush = 1'b0;
      stall_inc    = 1'b0;
      flush_inc    = 1'b0;
      if (rst) begin
         if_id_flush  = 1'b1;
         id_ex_flush  = 1'b1;
         ex_mem_flush = 1'b1;
      end else if (redir) begin
         // Redirect wins over stall, halt and drain; a drain in progress is abandoned.
         pc_write     = 1'b1;
         if_id_write  = 1'b1;
         if_id_flush  = 1'b1;
         id_ex_flush  = 1'b1;
         ex_mem_flush = 1'b1;
         flush_inc    = 1'b1;
         state_d      = ST_RUN;
         drain_d      = 2'd0;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (lu_hit) begin
                  id_ex_flush = 1'b1;
                  stall_inc   = 1'b1;
               end else if (id_halt) begin
                  id_ex_flush = 1'b1;
                  state_d     = ST_DRAIN;
                  drain_d     = DRAIN_DEPTH;
               end else begin
                  pc_write    = 1'b1;
                  if_id_write = 1'b1;
               end
            end
            ST_DRAIN: begin
               if_id_flush = 1'b1;
               if (drain_q == 2'd0) begin
                  state_d = ST_HALTED;
               end else begin
                  drain_d = drain_q - 2'd1;
               end
            end
            ST_HALTED: begin
            end
            default: begin
               state_d = ST_RUN;
               drain_d = 2'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_RUN;
         drain_q <= 2'd0;
      end else begin
         state_q <= state_d;
         drain_q <= drain_d;
      end
   end

   assign halted = (state_q == ST_HALTED);

   sat_counter16 u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc_i (stall_inc),
      .cnt_o (stall_cnt)
   );

   sat_counter16 u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc_i (flush_inc),
      .cnt_o (flush_cnt)
   );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: a behavioural model predicts every
// cycle's outputs, a separate monitor compares them against the DUT.
module tb_pipe_hazard_ctrl;

   logic        clk;
   logic        rst;
   logic [4:0]  id_rs;
   logic [4:0]  id_rt;
   logic        ex_memread;
   logic [4:0]  ex_rt;
   logic        mem_redirect;
   logic        id_halt;
   logic        pc_write;
   logic        if_id_write;
   logic        if_id_flush;
   logic        id_ex_flush;
   logic        ex_mem_flush;
   logic        halted;
   logic [15:0] stall_cnt;
   logic [15:0] flush_cnt;

   pipe_hazard_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .ex_memread   (ex_memread),
      .ex_rt        (ex_rt),
      .mem_redirect (mem_redirect),
      .id_halt      (id_halt),
      .pc_write     (pc_write),
      .if_id_write  (if_id_write),
      .if_id_flush  (if_id_flush),
      .id_ex_flush  (id_ex_flush),
      .ex_mem_flush (ex_mem_flush),
      .halted       (halted),
      .stall_cnt    (stall_cnt),
      .flush_cnt    (flush_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        pc_w;
      logic        ifid_w;
      logic        ifid_f;
      logic        idex_f;
      logic        exmem_f;
      logic        hlt;
      logic [15:0] stalls;
      logic [15:0] flushes;
   } exp_t;

   typedef struct {
      exp_t  e;
      string tag;
   } sb_t;

   sb_t q_exp[$];
   int  total = 0;
   int  bad   = 0;
   bit  stim_done = 0;

   // Reference model: pipeline mode, remaining drain cycles, event tallies.
   int m_mode   = 0;   // 0 run, 1 drain, 2 halted
   int m_drain  = 0;
   int m_stalls = 0;
   int m_flush  = 0;

   function automatic int sat_inc(input int v);
      return (v >= 65535) ? 65535 : v + 1;
   endfunction

   task automatic drive(input bit r, input int rs, input int rt, input bit mr,
                        input int ert, input bit rd, input bit hl, input string tag);
      exp_t e;
      bit   hazard;
      @(posedge clk);
      #1;
      rst = r; id_rs = rs[4:0]; id_rt = rt[4:0]; ex_memread = mr;
      ex_rt = ert[4:0]; mem_redirect = rd; id_halt = hl;

      e = '0;
      e.hlt     = (m_mode == 2);
      e.stalls  = m_stalls[15:0];
      e.flushes = m_flush[15:0];
      hazard = mr && (ert != 0) && (ert == rs || ert == rt);
      if (r) begin
         {e.pc_w, e.ifid_w, e.ifid_f, e.idex_f, e.exmem_f} = 5'b00111;
         m_mode = 0; m_drain = 0; m_stalls = 0; m_flush = 0;
      end else if (m_mode == 2) begin
         {e.pc_w, e.ifid_w, e.ifid_f, e.idex_f, e.exmem_f} = 5'b00000;
      end else if (rd) begin
         {e.pc_w, e.ifid_w, e.ifid_f, e.idex_f, e.exmem_f} = 5'b11111;
         m_flush = sat_inc(m_flush);
         m_mode = 0; m_drain = 0;
      end else if (m_mode == 1) begin
         {e.pc_w, e.ifid_w, e.ifid_f, e.idex_f, e.exmem_f} = 5'b00100;
         if (m_drain == 0) m_mode = 2;
         else m_drain = m_drain - 1;
      end else if (hazard) begin
         {e.pc_w, e.ifid_w, e.ifid_f, e.idex_f, e.exmem_f} = 5'b00010;
         m_stalls = sat_inc(m_stalls);
      end else if (hl) begin
         {e.pc_w, e.ifid_w, e.ifid_f, e.idex_f, e.exmem_f} = 5'b00010;
         m_mode = 1; m_drain = 3;
      end else begin
         {e.pc_w, e.ifid_w, e.ifid_f, e.idex_f, e.exmem_f} = 5'b11000;
      end
      q_exp.push_back('{e: e, tag: tag});
   endtask

   task automatic idle(input int n, input string tag);
      for (int i = 0; i < n; i++) drive(0, 1, 2, 0, 0, 0, 0, tag);
   endtask

   // Monitor: compare DUT outputs mid-cycle against the oldest prediction.
   initial begin
      sb_t  s;
      exp_t act;
      forever begin
         @(negedge clk);
         if (q_exp.size() > 0) begin
            s   = q_exp.pop_front();
            act = {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush,
                   halted, stall_cnt, flush_cnt};
            total++;
            if (act !== s.e) begin
               bad++;
               $display("FAIL %s t=%0t: got pcw=%b ifw=%b iff=%b ief=%b emf=%b hlt=%b stall=%h flush=%h, want pcw=%b ifw=%b iff=%b ief=%b emf=%b hlt=%b stall=%h flush=%h",
                        s.tag, $time, act.pc_w, act.ifid_w, act.ifid_f, act.idex_f, act.exmem_f,
                        act.hlt, act.stalls, act.flushes, s.e.pc_w, s.e.ifid_w, s.e.ifid_f,
                        s.e.idex_f, s.e.exmem_f, s.e.hlt, s.e.stalls, s.e.flushes);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got stim_done=%0d want 1", stim_done);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; id_rs = '0; id_rt = '0; ex_memread = 1'b0; ex_rt = '0;
      mem_redirect = 1'b0; id_halt = 1'b0;

      drive(1, 0, 0, 0, 0, 0, 0, "reset");
      idle(2, "post_reset");

      drive(0, 8, 3, 1, 8, 0, 0, "loaduse_rs");
      idle(2, "after_loaduse");
      drive(0, 4, 9, 1, 9, 0, 0, "loaduse_rt");
      idle(1, "after_loaduse_rt");

      drive(0, 0, 0, 1, 0, 0, 0, "r0_no_stall");
      drive(0, 6, 7, 1, 5, 0, 0, "no_match");
      idle(1, "after_r0");

      drive(1, 0, 0, 0, 0, 0, 0, "reset2");
      drive(0, 1, 5, 1, 5, 1, 0, "redir_over_lu");
      idle(2, "after_redir");

      drive(0, 3, 4, 1, 3, 0, 1, "halt_with_lu");
      drive(0, 1, 2, 0, 0, 0, 1, "halt");
      for (int i = 0; i < 4; i++) drive(0, 1, 2, 1, 1, 0, 1, "drain");
      for (int i = 0; i < 12; i++) drive(0, 1, 1, 1, 1, i[0], 1, "halted_hold");

      drive(1, 0, 0, 0, 0, 0, 0, "reset3");
      drive(0, 1, 2, 0, 0, 0, 1, "halt2");
      drive(0, 1, 2, 0, 0, 0, 0, "drain1");
      drive(0, 1, 2, 0, 0, 1, 0, "drain_abort");
      idle(3, "after_abort");

      drive(1, 0, 0, 0, 0, 0, 0, "reset4");
      for (int i = 0; i < 65534; i++) drive(0, 1, 2, 0, 0, 1, 0, "flush_fill");
      for (int i = 0; i < 3; i++) drive(0, 1, 2, 0, 0, 1, 0, "flush_sat");
      idle(2, "flush_saturated");
      drive(1, 0, 0, 0, 0, 0, 0, "reset5");
      idle(2, "after_reset5");

      for (int i = 0; i < 3000; i++) begin
         drive($urandom_range(0, 99) < 2,
               $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 1), $urandom_range(0, 3),
               $urandom_range(0, 99) < 10,
               $urandom_range(0, 99) < 4, "random");
      end

      stim_done = 1;
      @(posedge clk);
      for (int i = 0; i < 10 && q_exp.size() > 0; i++) @(posedge clk);
      @(posedge clk);
      total++;
      if (q_exp.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain: got %0d pending, want 0", q_exp.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-003 SHALL have ports id_rs and id_rt, input, 5 each: source register fields of the instruction in ID.
REQ-004 SHALL have ports ex_memread (input, 1) and ex_rt (input, 5): the load flag and destination field of the ID_EX bank outputs.
REQ-005 SHALL have port mem_redirect, input, 1: a taken branch or jump resolved in MEM this cycle.
REQ-006 SHALL have port id_halt, input, 1: the instruction in ID is the halt opcode 32'hFFFFFFFF.
REQ-007 SHALL have port pc_write, output, 1: PC update enable.
REQ-008 SHALL have port if_id_write, output, 1: IF_ID bank load enable.
REQ-009 SHALL have port if_id_flush, output, 1: IF_ID bank synchronous clear.
REQ-010 SHALL have port id_ex_flush, output, 1: ID_EX bank synchronous clear (bubble); it is ORed with rst outside this block.
REQ-011 SHALL have port ex_mem_flush, output, 1: EX_MEM bank synchronous clear.
REQ-012 SHALL have port halted, output, 1: the pipeline has drained after a halt.
REQ-013 SHALL have ports stall_cnt and flush_cnt, output, 16 each: saturating performance counters.

Function
REQ-014 SHALL implement FSM states RUN, DRAIN and HALTED; control outputs are combinational from the state and the inputs.
REQ-015 SHALL detect load-use in RUN when ex_memread=1, ex_rt!=0, and ex_rt equals id_rs or id_rt.
REQ-016 On load-use with no redirect, SHALL drive pc_write=0, if_id_write=0, id_ex_flush=1 for exactly that cycle; the hazard clears the next cycle without extra state.
REQ-017 On mem_redirect=1, in RUN or DRAIN, SHALL drive if_id_flush=1, id_ex_flush=1, ex_mem_flush=1, pc_write=1, if_id_write=1.
REQ-018 Redirect SHALL take priority over load-use and halt in the same cycle.
REQ-019 In RUN with id_halt=1, no redirect and no load-use, SHALL drive pc_write=0, if_id_write=0, id_ex_flush=1, and go to DRAIN with drain counter=3.
REQ-020 Halt coinciding with load-use SHALL first take the load-use stall; halt is re-evaluated next cycle.
REQ-021 In DRAIN SHALL drive pc_write=0, if_id_write=0, if_id_flush=1, and decrement the drain counter each cycle.
REQ-022 DRAIN SHALL go to HALTED on the cycle after the counter reads 0, so DRAIN lasts 4 cycles.
REQ-023 mem_redirect during DRAIN SHALL abort the drain: return to RUN, apply REQ-017, and clear the drain counter.
REQ-024 In HALTED SHALL hold pc_write=0, if_id_write=0, all flushes=0, halted=1, ignoring all inputs until rst.
REQ-025 In RUN with no event, SHALL drive pc_write=1, if_id_write=1, all flushes=0.
REQ-026 stall_cnt SHALL increment on each load-use stall cycle; flush_cnt SHALL increment on each redirect cycle; both saturate at 16'hFFFF with no wrap.

Reset
REQ-027 With rst=1 at a clock edge, SHALL enter RUN with the drain counter=0, halted=0, stall_cnt=0, flush_cnt=0; this applies from any state, mid-drain included.
REQ-028 While rst=1, outputs SHALL be pc_write=0, if_id_write=0, and all flushes=1.

Structure
REQ-029 SHALL place the FSM state encoding (2 bits), the drain depth constant (3) and the halt opcode in the shared pipeline package.
REQ-030 SHALL instantiate one sub-module, sat_counter16, twice for stall_cnt and flush_cnt.

Verification
REQ-031 Scenario: ex_memread=1, ex_rt=8, id_rs=8 for 1 cycle -> pc_write=0, if_id_write=0, id_ex_flush=1 for 1 cycle, stall_cnt=1.
REQ-032 Scenario: ex_memread=1, ex_rt=0, id_rs=0 -> no stall; pc_write=1, stall_cnt unchanged.
REQ-033 Scenario: mem_redirect=1 together with load-use (ex_rt=5, id_rt=5) -> all three flushes=1, pc_write=1, flush_cnt=1, stall_cnt=0.
REQ-034 Scenario: id_halt=1 in RUN -> DRAIN for 4 cycles with if_id_flush=1, then halted=1 held for 10+ cycles.
REQ-035 Scenario: halt, then mem_redirect on the 2nd DRAIN cycle -> state RUN, halted=0, pc_write=1 on the following cycle.
REQ-036 Scenario: preload flush_cnt to 16'hFFFE, apply 3 redirects -> flush_cnt=16'hFFFF; then rst=1 for one cycle -> all counters=0 and state RUN.
